// File: rtl/pbkdf2.sv
// Single-block PBKDF2-HMAC-SHA512 (dkLen = 64) with an iterative one-round-per-cycle
// SHA-512 compression core; a run starts on reset release and ends in a terminal DONE.
module pbkdf2 #(
  parameter logic [511:0] salt       = '0,
  parameter int           SALT_LEN   = 64,
  parameter int           ITERATIONS = 2048
) (
  input  logic              clk,
  input  logic              reset,
  output logic              done,
  input  logic [0:127][8:0] key,
  output logic [511:0]      result
);

  localparam int IW = ($clog2(ITERATIONS + 1) > 12) ? $clog2(ITERATIONS + 1) : 12;
  localparam logic [6:0] LAST_CNT = 7'd81;

  localparam logic [63:0] K [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [511:0] IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  // First inner block: salt || INT(1) || 0x80 || zeros || bit length, fixed at elaboration.
  localparam logic [511:0]  SALT_MASK = ~({512{1'b1}} >> (8 * SALT_LEN));
  localparam logic [1023:0] SALT_BLK  = {salt & SALT_MASK, 512'd0}
                                      | ({984'd0, 32'd1, 8'h80} << (1024 - 40 - 8 * SALT_LEN))
                                      | 1024'((128 + SALT_LEN + 4) * 8);

  typedef enum logic [2:0] {
    S_RESET, S_CAPTURE, S_PAD_I, S_PAD_O, S_INNER, S_OUTER, S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [6:0]          cnt_reg;
  logic [IW-1:0]       iter_reg;
  logic [1023:0]       key_reg;
  logic [7:0][63:0]    is_reg, os_reg, dig_reg, t_reg;
  logic [7:0][63:0]    st_reg;
  logic [15:0][63:0]   w_reg;

  logic [1023:0]       key_flat;
  logic [127:0]        key_b8;
  logic                unused_key_b8;
  logic [7:0][63:0]    chain, hsum;
  logic [1023:0]       blk;
  logic [63:0]         t1, t2, w_new, k_word;
  logic [6:0]          kidx;
  logic                last, more_iter, busy;

  function automatic logic [63:0] bsig0(input logic [63:0] x);
    return {x[27:0], x[63:28]} ^ {x[33:0], x[63:34]} ^ {x[38:0], x[63:39]};
  endfunction
  function automatic logic [63:0] bsig1(input logic [63:0] x);
    return {x[13:0], x[63:14]} ^ {x[17:0], x[63:18]} ^ {x[40:0], x[63:41]};
  endfunction
  function automatic logic [63:0] ssig0(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction
  function automatic logic [63:0] ssig1(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  // Bit 8 of each key element carries nothing.
  for (genvar gi = 0; gi < 128; gi++) begin : g_key
    assign key_flat[1023 - 8*gi -: 8] = key[gi][7:0];
    assign key_b8[gi]                 = key[gi][8];
  end
  assign unused_key_b8 = ^key_b8;

  for (genvar gi = 0; gi < 8; gi++) begin : g_sum
    assign hsum[gi] = chain[gi] + st_reg[gi];
  end

  assign last      = (cnt_reg == LAST_CNT);
  assign more_iter = (iter_reg < IW'(ITERATIONS));
  assign busy      = (state_reg == S_PAD_I) || (state_reg == S_PAD_O) ||
                     (state_reg == S_INNER) || (state_reg == S_OUTER);
  assign done      = (state_reg == S_DONE);
  assign result    = t_reg;

  always_comb begin
    chain = IV;
    blk   = {dig_reg, 8'h80, 376'd0, 128'd1536};
    case (state_reg)
      S_PAD_I: blk = key_reg ^ {128{8'h36}};
      S_PAD_O: blk = key_reg ^ {128{8'h5c}};
      S_INNER: begin
        chain = is_reg;
        if (iter_reg == IW'(1)) blk = SALT_BLK;
      end
      S_OUTER: chain = os_reg;
      default: ;
    endcase
  end

  // Window: w_reg[15] is W[t]; st_reg[7..0] = a..h.
  always_comb begin
    kidx   = cnt_reg - 7'd1;
    k_word = (cnt_reg != 7'd0 && cnt_reg <= 7'd80) ? K[kidx] : 64'd0;
    t1 = st_reg[0] + bsig1(st_reg[3]) + ((st_reg[3] & st_reg[2]) ^ (~st_reg[3] & st_reg[1]))
       + k_word + w_reg[15];
    t2 = bsig0(st_reg[7]) + ((st_reg[7] & st_reg[6]) ^ (st_reg[7] & st_reg[5]) ^ (st_reg[6] & st_reg[5]));
    w_new = ssig1(w_reg[1]) + w_reg[6] + ssig0(w_reg[14]) + w_reg[15];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET:   state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_PAD_I;
      S_PAD_I:   if (last) state_next = S_PAD_O;
      S_PAD_O:   if (last) state_next = S_INNER;
      S_INNER:   if (last) state_next = S_OUTER;
      S_OUTER:   if (last) state_next = more_iter ? S_INNER : S_DONE;
      default:   state_next = S_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_RESET;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg  <= '0;
      iter_reg <= IW'(1);
      key_reg  <= '0;
      is_reg   <= '0;
      os_reg   <= '0;
      dig_reg  <= '0;
      t_reg    <= '0;
      st_reg   <= '0;
      w_reg    <= '0;
    end else if (state_reg == S_RESET) begin
      key_reg  <= key_flat;
      t_reg    <= '0;
      iter_reg <= IW'(1);
    end else if (busy) begin
      cnt_reg <= last ? 7'd0 : cnt_reg + 7'd1;
      if (cnt_reg == 7'd0) begin
        st_reg <= chain;
        w_reg  <= blk;
      end else if (!last) begin
        st_reg <= {t1 + t2, st_reg[7], st_reg[6], st_reg[5], st_reg[4] + t1, st_reg[3], st_reg[2], st_reg[1]};
        w_reg  <= {w_reg[14:0], w_new};
      end else begin
        case (state_reg)
          S_PAD_I: is_reg  <= hsum;
          S_PAD_O: os_reg  <= hsum;
          S_INNER: dig_reg <= hsum;
          default: begin
            dig_reg <= hsum;
            t_reg   <= t_reg ^ hsum;
            if (more_iter) iter_reg <= iter_reg + IW'(1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pbkdf2.sv
// Directed bench for pbkdf2: a straightforward full-schedule SHA-512 / PBKDF2 reference
// model, latency and hold checks, key-capture and asynchronous-abort behaviour.
module tb_pbkdf2;

  localparam int ITER = 3;
  localparam int SL   = 14;
  localparam logic [511:0] SALT = {"mnemonicTREZOR", 400'd0};
  localparam int LAT  = 2 + 82 * (2 + 2 * ITER);
  localparam string MNEM =
    "abandon abandon abandon abandon abandon abandon abandon abandon abandon abandon abandon about";

  localparam logic [511:0] ABC_DIGEST =
    512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;

  localparam logic [511:0] IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [63:0] KC [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              done;
  logic [0:127][8:0] key;
  logic [511:0]      result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pbkdf2 #(.salt(SALT), .SALT_LEN(SL), .ITERATIONS(ITER)) dut (
    .clk(clk), .reset(reset), .done(done), .key(key), .result(result)
  );

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [511:0] m_compress(input logic [511:0] h, input logic [1023:0] b);
    logic [63:0] w [80];
    logic [63:0] v [8];
    logic [63:0] x1, x2, s0, s1;
    logic [511:0] r;
    for (int j = 0; j < 16; j++) w[j] = b[1023 - 64*j -: 64];
    for (int j = 16; j < 80; j++) begin
      s0 = ror(w[j-15], 1) ^ ror(w[j-15], 8) ^ (w[j-15] >> 7);
      s1 = ror(w[j-2], 19) ^ ror(w[j-2], 61) ^ (w[j-2] >> 6);
      w[j] = s1 + w[j-7] + s0 + w[j-16];
    end
    for (int j = 0; j < 8; j++) v[j] = h[511 - 64*j -: 64];
    for (int t = 0; t < 80; t++) begin
      x1 = v[7] + (ror(v[4], 14) ^ ror(v[4], 18) ^ ror(v[4], 41))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KC[t] + w[t];
      x2 = (ror(v[0], 28) ^ ror(v[0], 34) ^ ror(v[0], 39))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
    end
    for (int j = 0; j < 8; j++) r[511 - 64*j -: 64] = h[511 - 64*j -: 64] + v[j];
    return r;
  endfunction

  function automatic logic [1023:0] m_salt_block();
    logic [7:0] b [128];
    logic [1023:0] r;
    int len;
    for (int i = 0; i < 128; i++) b[i] = 8'h00;
    for (int i = 0; i < SL; i++) b[i] = SALT[511 - 8*i -: 8];
    b[SL+3] = 8'h01;
    b[SL+4] = 8'h80;
    len = (128 + SL + 4) * 8;
    b[126] = 8'(len >> 8);
    b[127] = 8'(len);
    for (int i = 0; i < 128; i++) r[1023 - 8*i -: 8] = b[i];
    return r;
  endfunction

  function automatic logic [511:0] m_pbkdf2(input logic [1023:0] k, input int iters);
    logic [511:0] is_h, os_h, inner, u, t;
    is_h  = m_compress(IV, k ^ {128{8'h36}});
    os_h  = m_compress(IV, k ^ {128{8'h5c}});
    inner = m_compress(is_h, m_salt_block());
    u     = m_compress(os_h, {inner, 8'h80, 376'd0, 128'd1536});
    t     = u;
    for (int i = 2; i <= iters; i++) begin
      inner = m_compress(is_h, {u, 8'h80, 376'd0, 128'd1536});
      u     = m_compress(os_h, {inner, 8'h80, 376'd0, 128'd1536});
      t     = t ^ u;
    end
    return t;
  endfunction

  task automatic set_key(input string s, input logic b8);
    for (int i = 0; i < 128; i++) key[i] = {b8, (i < s.len()) ? s[i] : 8'h00};
  endtask

  function automatic logic [1023:0] key_bytes();
    logic [1023:0] r;
    for (int i = 0; i < 128; i++) r[1023 - 8*i -: 8] = key[i][7:0];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Releases reset on a falling edge and counts rising edges until done; change_at > 0
  // swaps in an all-zero key just after that edge.
  task automatic run(input string tag, input int change_at, output int edge_n);
    @(negedge clk);
    reset  = 1'b1;
    edge_n = -1;
    for (int n = 1; n <= LAT + 50; n++) begin
      @(posedge clk);
      #1;
      if (n == change_at) set_key("", 1'b0);
      if (done === 1'b1) begin
        edge_n = n;
        break;
      end
    end
    $display("run %s: done at edge %0d, result=%h", tag, edge_n, result);
  endtask

  logic [511:0] exp_zero, exp_tea, exp_mnem, exp_u1;
  int edge_n;
  int bad;

  initial begin
    set_key("", 1'b0);
    check_eq("model_kat_abc", m_compress(IV, {24'h616263, 8'h80, 864'd0, 128'd24}), ABC_DIGEST);

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_done", 512'(done), 512'd0);
    check_eq("reset_result", result, 512'd0);

    exp_zero = m_pbkdf2(key_bytes(), ITER);
    run("zero_key", 0, edge_n);
    check_eq("zero_edge", 512'(edge_n), 512'(LAT));
    check_eq("zero_result", result, exp_zero);

    do_reset();
    set_key("", 1'b1);
    run("zero_key_bit8", 0, edge_n);
    check_eq("bit8_edge", 512'(edge_n), 512'(LAT));
    check_eq("bit8_result", result, exp_zero);

    do_reset();
    set_key("teaCher", 1'b0);
    exp_tea = m_pbkdf2(key_bytes(), ITER);
    run("teaCher", 0, edge_n);
    check_eq("tea_edge", 512'(edge_n), 512'(LAT));
    check_eq("tea_result", result, exp_tea);

    do_reset();
    set_key(MNEM, 1'b0);
    exp_mnem = m_pbkdf2(key_bytes(), ITER);
    run("mnemonic", 0, edge_n);
    check_eq("mnem_edge", 512'(edge_n), 512'(LAT));
    check_eq("mnem_result", result, exp_mnem);

    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b1 || result !== exp_mnem) bad++;
    end
    $display("hold: %0d unstable cycles over 1000", bad);
    check_eq("hold_unstable", 512'(bad), 512'd0);
    check_eq("hold_done", 512'(done), 512'd1);
    check_eq("hold_result", result, exp_mnem);

    // Key swapped to zeros after capture: still the teaCher result.
    do_reset();
    set_key("teaCher", 1'b1);
    run("key_change", 3, edge_n);
    check_eq("keychg_edge", 512'(edge_n), 512'(LAT));
    check_eq("keychg_result", result, exp_tea);

    // Abort after the first OUTER, then rerun with a new key.
    do_reset();
    set_key(MNEM, 1'b0);
    exp_u1 = m_pbkdf2(key_bytes(), 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    check_eq("midrun_u1", result, exp_u1);
    check_eq("midrun_done", 512'(done), 512'd0);
    #2;
    reset = 1'b0;
    #1;
    $display("abort: done=%0b result=%h", done, result);
    check_eq("abort_done", 512'(done), 512'd0);
    check_eq("abort_result", result, 512'd0);
    set_key("", 1'b0);
    run("rerun", 0, edge_n);
    check_eq("rerun_edge", 512'(edge_n), 512'(LAT));
    check_eq("rerun_result", result, exp_zero);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
